gol_board_seeder: RTL and testbench

//  Parametrised board initialiser for the Game of Life core; replaces one-shot clear logic.
//  On start, sweeps the board one row per cycle and writes clear, all-alive, pseudo-random or streamed rows.

---
 rtl/gol_pkg.sv | 35 +++
 rtl/row_popcount.sv | 17 +
 rtl/gol_board_seeder.sv | 141 ++++++++++++++
 tb/tb_gol_board_seeder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life board seeder.
// Galois LFSR tap masks are right-shift form: the mask is XORed in when the shifted-out bit is 1.
package gol_pkg;

  typedef enum logic [1:0] {
    ModeClear  = 2'b00,
    ModeFill   = 2'b01,
    ModeRandom = 2'b10,
    ModeLoad   = 2'b11
  } seeder_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } seeder_state_e;

  localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] LFSR_TAPS_24 = 64'h0000_0000_00E1_0000;
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  // Maximal-length taps for the supported widths; other widths fall back to the 32-bit set.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      24:      return LFSR_TAPS_24;
      64:      return LFSR_TAPS_64;
      default: return LFSR_TAPS_32;
    endcase
  endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational population count of one board row.
module row_popcount #(
  parameter int unsigned W = 16,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/gol_board_seeder.sv
// Board initialiser: sweeps all rows once per start, writing clear, fill, LFSR or streamed data,
// pulses a stats clear and accumulates the seeded live-cell population.
module gol_board_seeder
  import gol_pkg::*;
#(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED_DEF = LFSR_W'(32'hACE1_0001),
  localparam int unsigned AW = $clog2(ROWS),
  localparam int unsigned CW = $clog2(ROWS * COLS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LFSR_W-1:0] seed,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [COLS-1:0]   in_data,
  output logic              in_ready,
  output logic              row_we,
  output logic [AW-1:0]     row_addr,
  output logic [COLS-1:0]   row_data,
  output logic              stats_clr,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     alive_cnt
);

  localparam int unsigned PW = $clog2(COLS + 1);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  seeder_state_e     state_q, state_d;
  seeder_mode_e      mode_q, mode_eff;
  logic [LFSR_W-1:0] lfsr_q, lfsr_src, lfsr_next, seed_eff;
  logic [AW-1:0]     ptr_q;
  logic              row_we_q, stats_clr_q, done_q;
  logic [AW-1:0]     row_addr_q;
  logic [COLS-1:0]   row_data_q, wdata;
  logic [CW-1:0]     alive_q;
  logic [PW-1:0]     pop;
  logic              launch, issue;

  row_popcount #(
    .W(COLS)
  ) u_row_popcount (
    .bits  (wdata),
    .count (pop)
  );

  // The start edge itself issues row 0 for the self-timed modes, so the sweep is exactly ROWS cycles.
  always_comb begin
    seed_eff  = (seed == '0) ? SEED_DEF : seed;
    launch    = (state_q == StIdle) && start;
    mode_eff  = launch ? seeder_mode_e'(mode) : mode_q;
    lfsr_src  = launch ? seed_eff : lfsr_q;
    lfsr_next = lfsr_src >> 1;
    if (lfsr_src[0]) begin
      lfsr_next = lfsr_next ^ TAPS;
    end

    unique case (mode_eff)
      ModeClear:  wdata = '0;
      ModeFill:   wdata = '1;
      ModeRandom: wdata = lfsr_src[COLS-1:0];
      default:    wdata = in_data;
    endcase

    issue   = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          issue   = (mode_eff != ModeLoad);
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          issue = (mode_q != ModeLoad) || in_valid;
          if (issue && (ptr_q == LAST_ROW)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= ModeClear;
      lfsr_q      <= SEED_DEF;
      ptr_q       <= '0;
      row_we_q    <= 1'b0;
      row_addr_q  <= '0;
      row_data_q  <= '0;
      stats_clr_q <= 1'b0;
      done_q      <= 1'b0;
      alive_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_we_q    <= issue;
      stats_clr_q <= launch;
      done_q      <= (state_q == StDone);
      if (issue) begin
        row_addr_q <= launch ? '0 : ptr_q;
        row_data_q <= wdata;
      end
      if (launch) begin
        mode_q  <= seeder_mode_e'(mode);
        alive_q <= issue ? CW'(pop) : '0;
        ptr_q   <= issue ? AW'(1) : '0;
      end else if (issue) begin
        alive_q <= alive_q + CW'(pop);
        ptr_q   <= ptr_q + AW'(1);
      end
      if (issue && (mode_eff == ModeRandom)) begin
        lfsr_q <= lfsr_next;
      end else if (launch) begin
        lfsr_q <= seed_eff;
      end
    end
  end

  assign in_ready  = (state_q == StRun) && (mode_q == ModeLoad);
  assign busy      = (state_q == StRun);
  assign row_we    = row_we_q;
  assign row_addr  = row_addr_q;
  assign row_data  = row_data_q;
  assign stats_clr = stats_clr_q;
  assign done      = done_q;
  assign alive_cnt = alive_q;

endmodule

// File: tb/tb_gol_board_seeder.sv
// Directed bench for gol_board_seeder: all four modes, mid-sweep start, abort and reset.
module tb_gol_board_seeder;

  localparam logic [31:0] SEED_DEF = 32'hACE1_0001;
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] seed = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, row_we, stats_clr, busy, done;
  logic [3:0]  row_addr;
  logic [15:0] row_data;
  logic [8:0]  alive_cnt;

  gol_board_seeder #(
    .ROWS   (16),
    .COLS   (16),
    .LFSR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .row_we    (row_we),
    .row_addr  (row_addr),
    .row_data  (row_data),
    .stats_clr (stats_clr),
    .busy      (busy),
    .done      (done),
    .alive_cnt (alive_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Event log sampled on the falling edge, stamped with the number of rising edges so far.
  logic [3:0]  wa[$];
  logic [15:0] wd[$];
  int          we_e[$];
  int          done_e[$];
  int          sc_e[$];

  always @(negedge clk) begin
    if (row_we) begin
      wa.push_back(row_addr);
      wd.push_back(row_data);
      we_e.push_back(edge_n);
    end
    if (done) done_e.push_back(edge_n);
    if (stats_clr) sc_e.push_back(edge_n);
  end

  int n_tests = 0;
  int n_fail = 0;
  int s_edge, wbase, dbase, cbase;
  logic [15:0] exp_rows[16];
  logic [15:0] first_seq[16];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [31:0] s);
    mode  = m;
    seed  = s;
    start = 1'b1;
    wbase = wa.size();
    dbase = done_e.size();
    cbase = sc_e.size();
    tick();
    s_edge = edge_n;
    start  = 1'b0;
  endtask

  task automatic check_rows(input string tag, input int n);
    int got;
    got = wa.size() - wbase;
    check_eq({tag, "_nwrites"}, got, n);
    for (int j = 0; j < n && j < got; j++) begin
      check_eq($sformatf("%s_addr%0d", tag, j), wa[wbase + j], j);
      check_eq($sformatf("%s_data%0d", tag, j), wd[wbase + j], exp_rows[j]);
    end
  endtask

  function automatic int done_rel();
    return (done_e.size() > dbase) ? done_e[dbase] - s_edge + 1 : -1;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
  endfunction

  initial begin
    logic [31:0] l;
    int          sum;
    int          diffs;

    #2;
    check_eq("rst_row_we", row_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_stats_clr", stats_clr, 0);
    check_eq("rst_alive", alive_cnt, 0);
    check_eq("rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // CLEAR sweep with cycle-accurate timing
    for (int j = 0; j < 16; j++) exp_rows[j] = 16'h0000;
    do_start(2'b00, 32'h0);
    check_eq("clr_busy", busy, 1);
    repeat (20) tick();
    check_rows("clr", 16);
    check_eq("clr_stats_n", sc_e.size() - cbase, 1);
    check_eq("clr_stats_rel", (sc_e.size() > cbase) ? sc_e[cbase] - s_edge + 1 : -1, 1);
    check_eq("clr_first_we_rel", (wa.size() > wbase) ? we_e[wbase] - s_edge + 1 : -1, 1);
    check_eq("clr_last_we_rel", (wa.size() - wbase == 16) ? we_e[wbase + 15] - s_edge + 1 : -1,
             16);
    check_eq("clr_done_n", done_e.size() - dbase, 1);
    check_eq("clr_done_rel", done_rel(), 17);
    check_eq("clr_alive", alive_cnt, 0);
    check_eq("clr_busy_end", busy, 0);

    // FILL with a stray CLEAR start mid-sweep
    for (int j = 0; j < 16; j++) exp_rows[j] = 16'hFFFF;
    do_start(2'b01, 32'h0);
    repeat (5) tick();
    mode  = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check_rows("fill", 16);
    check_eq("fill_stats_n", sc_e.size() - cbase, 1);
    check_eq("fill_done_n", done_e.size() - dbase, 1);
    check_eq("fill_done_rel", done_rel(), 17);
    check_eq("fill_alive", alive_cnt, 256);

    // RANDOM from the default seed
    l = SEED_DEF;
    sum = 0;
    for (int j = 0; j < 16; j++) begin
      exp_rows[j] = l[15:0];
      sum += $countones(l[15:0]);
      l = lfsr_step(l);
    end
    do_start(2'b10, 32'h0);
    repeat (20) tick();
    check_rows("rnd0", 16);
    check_eq("rnd0_row1_hand", (wa.size() - wbase > 1) ? wd[wbase + 1] : 16'h0, 16'h8003);
    check_eq("rnd0_alive", alive_cnt, sum);
    check_eq("rnd0_done_rel", done_rel(), 17);
    for (int j = 0; j < 16; j++) first_seq[j] = (wa.size() - wbase > j) ? wd[wbase + j] : 16'h0;

    // RANDOM from seed 1
    l = 32'h1;
    sum = 0;
    for (int j = 0; j < 16; j++) begin
      exp_rows[j] = l[15:0];
      sum += $countones(l[15:0]);
      l = lfsr_step(l);
    end
    do_start(2'b10, 32'h1);
    repeat (20) tick();
    check_rows("rnd1", 16);
    check_eq("rnd1_row1_hand", (wa.size() - wbase > 1) ? wd[wbase + 1] : 16'h0, 16'h0003);
    check_eq("rnd1_alive", alive_cnt, sum);
    diffs = 0;
    for (int j = 0; j < 16 && j < wa.size() - wbase; j++) begin
      if (wd[wbase + j] != first_seq[j]) diffs++;
    end
    check_eq("rnd1_differs", diffs > 0, 1);

    // LOAD with a 1,0,0 valid pattern
    for (int j = 0; j < 16; j++) exp_rows[j] = 16'h8001;
    do_start(2'b11, 32'h0);
    for (int k = 0; k < 46; k++) begin
      if (k < 2) check_eq($sformatf("load_ready%0d", k), in_ready, 1);
      in_valid = (k % 3 == 0);
      in_data  = in_valid ? 16'h8001 : 16'h1234;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check_rows("load", 16);
    check_eq("load_w1_rel", (wa.size() - wbase > 1) ? we_e[wbase + 1] - s_edge + 1 : -1, 5);
    check_eq("load_last_rel", (wa.size() - wbase == 16) ? we_e[wbase + 15] - s_edge + 1 : -1,
             47);
    check_eq("load_done_rel", done_rel(), 48);
    check_eq("load_alive", alive_cnt, 32);
    check_eq("load_ready_end", in_ready, 0);

    // abort after row 7, then a clean FILL
    for (int j = 0; j < 16; j++) exp_rows[j] = 16'hFFFF;
    do_start(2'b01, 32'h0);
    repeat (7) tick();
    check_eq("abort_at_row", row_addr, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    repeat (20) tick();
    check_rows("abort", 8);
    check_eq("abort_done_n", done_e.size() - dbase, 0);
    check_eq("abort_alive", alive_cnt, 128);
    do_start(2'b01, 32'h0);
    repeat (20) tick();
    check_rows("post_abort", 16);
    check_eq("post_abort_done_n", done_e.size() - dbase, 1);
    check_eq("post_abort_alive", alive_cnt, 256);

    // reset at row 5, then a clean CLEAR
    do_start(2'b01, 32'h0);
    repeat (5) tick();
    check_eq("rst_mid_at_row", row_addr, 5);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_we", row_we, 0);
    check_eq("rst_mid_addr", row_addr, 0);
    check_eq("rst_mid_data", row_data, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_alive", alive_cnt, 0);
    check_eq("rst_mid_done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_rel_busy", busy, 0);
    for (int j = 0; j < 16; j++) exp_rows[j] = 16'h0000;
    do_start(2'b00, 32'h0);
    repeat (20) tick();
    check_rows("post_rst", 16);
    check_eq("post_rst_done_rel", done_rel(), 17);
    check_eq("post_rst_alive", alive_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
